// File: rtl/adc_pipe_pkg.sv
// Shared types and defaults for the pipelined-ADC timing sequencer.
// The ADC_SEQ_BURST_EN build macro is consumed by adc_pipe_sequencer.
package adc_pipe_pkg;

    localparam int unsigned PH_CYC_DEF   = 1;
    localparam int unsigned FILL_LAT_DEF = 3;
    localparam int unsigned N_STAGES     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_G1,
        ST_P2,
        ST_G2
    } seq_state_e;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_pipe_phase_gen.sv
// Non-overlapping phase FSM: P1 / G1 / P2 / G2 per conversion period.
// Outputs are registered from the next-state decode so they track the state exactly.
module adc_pipe_phase_gen
    import adc_pipe_pkg::*;
#(
    parameter int unsigned PH_CYC = PH_CYC_DEF
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic end_run_i,
    output logic phi1_o,
    output logic phi2_o,
    output logic cmp_latch_o,
    output logic enc_en_o,
    output logic busy_o,
    output logic g2_next_c
);

    localparam int unsigned     PH_W    = cnt_width(PH_CYC);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_CYC - 1);

    seq_state_e      state, state_nx;
    logic [PH_W-1:0] ph_cnt, ph_cnt_nx;

    // Next-state logic; the phase counter only runs inside P1/P2.
    always_comb begin
        state_nx  = state;
        ph_cnt_nx = '0;
        case (state)
            ST_IDLE: if (start_i) state_nx = ST_P1;
            ST_P1: begin
                if (ph_cnt == PH_LAST) state_nx  = ST_G1;
                else                   ph_cnt_nx = ph_cnt + 1'b1;
            end
            ST_G1:   state_nx = ST_P2;
            ST_P2: begin
                if (ph_cnt == PH_LAST) state_nx  = ST_G2;
                else                   ph_cnt_nx = ph_cnt + 1'b1;
            end
            ST_G2:   state_nx = end_run_i ? ST_IDLE : ST_P1;
            default: state_nx = ST_IDLE;
        endcase
        g2_next_c = (state_nx == ST_G2);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            phi1_o      <= 1'b0;
            phi2_o      <= 1'b0;
            cmp_latch_o <= 1'b0;
            enc_en_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nx;
            ph_cnt      <= ph_cnt_nx;
            phi1_o      <= (state_nx == ST_P1);
            phi2_o      <= (state_nx == ST_P2);
            cmp_latch_o <= (state_nx == ST_G1);
            enc_en_o    <= (state_nx == ST_G2);
            busy_o      <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: rtl/adc_pipe_sequencer.sv
// Run control for the 3-stage pipelined ADC: start/stop, pipeline-fill masking, valid counting.
// Define ADC_SEQ_BURST_EN to add burst_len_i and fixed-length runs.
module adc_pipe_sequencer
    import adc_pipe_pkg::*;
#(
    parameter int unsigned PH_CYC   = PH_CYC_DEF,
    parameter int unsigned FILL_LAT = FILL_LAT_DEF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
`ifdef ADC_SEQ_BURST_EN
    input  logic [CNT_W-1:0] burst_len_i,
`endif
    output logic             phi1_o,
    output logic             phi2_o,
    output logic             cmp_latch_o,
    output logic             enc_en_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] conv_cnt_o
);

    localparam int unsigned       FILL_W   = cnt_width(FILL_LAT);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic              start_acc_c;
    logic              end_run_c;
    logic              burst_hit_c;
    logic              g2_next_c;
    logic              stop_pend;
    logic [FILL_W-1:0] fill_cnt;

    adc_pipe_phase_gen #(
        .PH_CYC (PH_CYC)
    ) u_phase_gen (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .end_run_i   (end_run_c),
        .phi1_o      (phi1_o),
        .phi2_o      (phi2_o),
        .cmp_latch_o (cmp_latch_o),
        .enc_en_o    (enc_en_o),
        .busy_o      (busy_o),
        .g2_next_c   (g2_next_c)
    );

`ifdef ADC_SEQ_BURST_EN
    logic [CNT_W-1:0] burst_len_q;

    // Burst ends on the G2 whose valid code brings the count up to the target.
    assign burst_hit_c = valid_o && (burst_len_q != '0) &&
                         (CNT_W'(conv_cnt_o + 1'b1) == burst_len_q);

    always_ff @(posedge clock_i) begin
        if (reset_i)          burst_len_q <= '0;
        else if (start_acc_c) burst_len_q <= burst_len_i;
    end
`else
    assign burst_hit_c = 1'b0;
`endif

    assign start_acc_c = start_i && !busy_o;
    assign end_run_c   = enc_en_o && (stop_pend || stop_i || burst_hit_c);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stop_pend  <= 1'b0;
            fill_cnt   <= '0;
            conv_cnt_o <= '0;
            valid_o    <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o  <= end_run_c;
            valid_o <= g2_next_c && (fill_cnt == FILL_MAX);
            if (start_acc_c) begin
                stop_pend  <= 1'b0;
                fill_cnt   <= '0;
                conv_cnt_o <= '0;
            end else begin
                if (end_run_c)             stop_pend <= 1'b0;
                else if (busy_o && stop_i) stop_pend <= 1'b1;
                if (enc_en_o && (fill_cnt != FILL_MAX))
                    fill_cnt <= fill_cnt + 1'b1;
                if (valid_o && (conv_cnt_o != CNT_MAX))
                    conv_cnt_o <= conv_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_pipe_sequencer.sv
// Scoreboard bench for adc_pipe_sequencer: PH_CYC=1 instance (a) and PH_CYC=3 instance (b).
module tb_adc_pipe_sequencer;

    logic clock_tb = 1'b0;
    always #5 clock_tb = ~clock_tb;

    logic        reset_tb;
    logic        start_a, stop_a, start_b, stop_b;
    logic [15:0] burst_a, burst_b;
    logic        phi1_a, phi2_a, cmp_a, enc_a, valid_a, busy_a, done_a;
    logic        phi1_b, phi2_b, cmp_b, enc_b, valid_b, busy_b, done_b;
    logic [15:0] conv_a, conv_b;

    adc_pipe_sequencer #(.PH_CYC(1), .FILL_LAT(3), .CNT_W(16)) dut_a (
        .clock_i     (clock_tb),
        .reset_i     (reset_tb),
        .start_i     (start_a),
        .stop_i      (stop_a),
`ifdef ADC_SEQ_BURST_EN
        .burst_len_i (burst_a),
`endif
        .phi1_o      (phi1_a),
        .phi2_o      (phi2_a),
        .cmp_latch_o (cmp_a),
        .enc_en_o    (enc_a),
        .valid_o     (valid_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .conv_cnt_o  (conv_a)
    );

    adc_pipe_sequencer #(.PH_CYC(3), .FILL_LAT(3), .CNT_W(16)) dut_b (
        .clock_i     (clock_tb),
        .reset_i     (reset_tb),
        .start_i     (start_b),
        .stop_i      (stop_b),
`ifdef ADC_SEQ_BURST_EN
        .burst_len_i (burst_b),
`endif
        .phi1_o      (phi1_b),
        .phi2_o      (phi2_b),
        .cmp_latch_o (cmp_b),
        .enc_en_o    (enc_b),
        .valid_o     (valid_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .conv_cnt_o  (conv_b)
    );

    typedef struct {
        int          cyc;
        logic        valid;
        logic [15:0] cnt;
    } enc_exp_t;

    enc_exp_t exp_q[$];
    enc_exp_t mon_e;
    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    logic     mon_en = 1'b0;

    always @(posedge clock_tb) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock_tb);
        #1;
    endtask

    // Expected encoder pulses of a PH_CYC=1 run on instance a started at cycle k.
    task automatic push_run(input int k, input int periods);
        enc_exp_t e;
        for (int p = 1; p <= periods; p++) begin
            e.cyc   = k + 4 * p - 1;
            e.valid = (p > 3);
            e.cnt   = (p > 3) ? 16'(p - 4) : 16'd0;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every encoder pulse on instance a is matched against the scoreboard.
    always @(negedge clock_tb) begin
        if (mon_en) begin
            if (valid_a) check("valid_needs_enc", int'(enc_a), 1);
            if (phi1_a)  check("phi_overlap_a", int'(phi2_a), 0);
            if (phi1_b)  check("phi_overlap_b", int'(phi2_b), 0);
            if (enc_a) begin
                check("enc_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("enc_cycle", cyc, mon_e.cyc);
                    check("enc_valid", int'(valid_a), int'(mon_e.valid));
                    check("enc_conv_cnt", int'(conv_a), int'(mon_e.cnt));
                end
            end
        end
    end

    int k, m;

    initial begin
        reset_tb = 1'b1;
        start_a  = 1'b1;
        stop_a   = 1'b0;
        start_b  = 1'b0;
        stop_b   = 1'b0;
        burst_a  = 16'd0;
        burst_b  = 16'd0;

        // Reset with start held: nothing may start.
        repeat (3) begin
            step();
            check("rst_busy", int'(busy_a), 0);
            check("rst_phi1", int'(phi1_a), 0);
            check("rst_enc", int'(enc_a), 0);
            check("rst_done", int'(done_a), 0);
            check("rst_conv", int'(conv_a), 0);
        end
        reset_tb = 1'b0;
        mon_en   = 1'b1;

        // Run 1: continuous, 8 full periods, then stopped in period 9.
        step();
        k = cyc;
        start_a = 1'b0;
        push_run(k, 9);
        check("start_busy", int'(busy_a), 1);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            check("pat_phi1", int'(phi1_a), int'(i % 4 == 0));
            check("pat_phi2", int'(phi2_a), int'(i % 4 == 2));
            check("pat_cmp", int'(cmp_a), int'(i % 4 == 1));
        end
        step();
        check("conv_after_8", int'(conv_a), 5);
        repeat (2) step();
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        check("stop_g2_completes", int'(enc_a), 1);
        step();
        check("run1_done", int'(done_a), 1);
        check("run1_busy", int'(busy_a), 0);
        check("run1_conv", int'(conv_a), 6);
        start_a = 1'b1;

        // Run 2: started in the done cycle, stopped during P2 of period 6.
        step();
        k = cyc;
        start_a = 1'b0;
        push_run(k, 6);
        check("run2_phi1", int'(phi1_a), 1);
        check("run2_conv_clr", int'(conv_a), 0);
        check("run2_done_clr", int'(done_a), 0);
        repeat (22) step();
        check("run2_p2", int'(phi2_a), 1);
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        step();
        check("run2_done", int'(done_a), 1);
        check("run2_busy", int'(busy_a), 0);
        check("run2_conv", int'(conv_a), 3);
        step();
        check("run2_done_1cyc", int'(done_a), 0);
        repeat (3) begin
            stop_a = 1'b1;
            step();
            stop_a = 1'b0;
            step();
            check("idle_stop_busy", int'(busy_a), 0);
            check("idle_stop_done", int'(done_a), 0);
            check("idle_stop_conv", int'(conv_a), 3);
        end

        // Run 3: start+stop together (start wins), then reset in P1 of period 2.
        start_a = 1'b1;
        stop_a  = 1'b1;
        step();
        k = cyc;
        start_a = 1'b0;
        stop_a  = 1'b0;
        push_run(k, 1);
        check("run3_started", int'(phi1_a), 1);
        check("run3_conv_clr", int'(conv_a), 0);
        repeat (4) step();
        check("run3_p1_period2", int'(phi1_a), 1);
        reset_tb = 1'b1;
        step();
        reset_tb = 1'b0;
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_phi1", int'(phi1_a), 0);
        check("midrst_done", int'(done_a), 0);
        check("midrst_conv", int'(conv_a), 0);
        repeat (3) begin
            step();
            check("postrst_done", int'(done_a), 0);
            check("postrst_busy", int'(busy_a), 0);
        end

        // Instance b, PH_CYC=3: period 8, mid-run start ignored.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            start_b = (i == 10);
            m = i % 8;
            check("b_phi1", int'(phi1_b), int'(m < 3));
            check("b_phi2", int'(phi2_b), int'(m >= 4 && m <= 6));
            check("b_cmp", int'(cmp_b), int'(m == 3));
            check("b_enc", int'(enc_b), int'(m == 7));
            check("b_busy", int'(busy_b), 1);
        end
        start_b = 1'b0;
        step();
        stop_b = 1'b1;
        step();
        stop_b = 1'b0;
        repeat (6) step();
        check("b_last_g2", int'(enc_b), 1);
        check("b_last_valid", int'(valid_b), 1);
        step();
        check("b_done", int'(done_b), 1);
        check("b_busy_end", int'(busy_b), 0);
        check("b_conv", int'(conv_b), 1);

`ifdef ADC_SEQ_BURST_EN
        // Burst of 5 valid codes ends on its own.
        burst_a = 16'd5;
        start_a = 1'b1;
        step();
        k = cyc;
        start_a = 1'b0;
        push_run(k, 8);
        repeat (32) step();
        check("burst_done", int'(done_a), 1);
        check("burst_busy", int'(busy_a), 0);
        check("burst_conv", int'(conv_a), 5);

        // burst_len 0: continuous past 50 periods.
        burst_a = 16'd0;
        start_a = 1'b1;
        step();
        k = cyc;
        start_a = 1'b0;
        push_run(k, 51);
        repeat (200) step();
        check("burst0_busy", int'(busy_a), 1);
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        repeat (3) step();
        check("burst0_done", int'(done_a), 1);
        check("burst0_conv", int'(conv_a), 48);
`endif

        repeat (4) step();
        check("enc_queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_pipe_sequencer.md
# adc_pipe_sequencer

Timing controller for the 3-stage 1.5-bit pipelined ADC. It generates the non-overlapping sample/amplify phases `phi1_o`/`phi2_o` for the MDAC stages, the comparator latch strobe, and the per-conversion clock enable for `adc_pipe_encoder_TOP`. It discards the codes produced while the pipeline fills, then flags each valid output code. It sits between the system control logic (start/stop) and the analog stages plus encoder.

## Interface
- `PH_CYC`, 1: clock cycles per active phase (phi1 and phi2); legal range ≥1.
- `FILL_LAT`, 3: number of initial `enc_en_o` pulses per run that do not assert `valid_o`.
- `CNT_W`, 16: width of `conv_cnt_o`, and of `burst_len_i` when it exists.
- `clock_i`  in  1  sole clock, rising edge.
- `reset_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  begin a run; sampled in IDLE only.
- `stop_i`  in  1  request end of run; sampled while busy.
- `burst_len_i`  in  CNT_W  conversions per run, 0 = continuous (only with `ADC_SEQ_BURST_EN`).
- `phi1_o`  out  1  stage sample phase (odd stages sample, even stages amplify).
- `phi2_o`  out  1  complementary phase, never high together with `phi1_o`.
- `cmp_latch_o`  out  1  sub-ADC comparator latch strobe.
- `enc_en_o`  out  1  one-cycle encoder clock enable per conversion period.
- `valid_o`  out  1  `enc_en_o` pulse that carries a valid code.
- `busy_o`  out  1  run in progress.
- `done_o`  out  1  one-cycle pulse when a run ends normally.
- `conv_cnt_o`  out  CNT_W  valid conversions in the current or last run.

## Operation
- FSM states: IDLE, P1, G1, P2, G2.
  - P1 and P2 each last `PH_CYC` cycles, counted by a phase counter.
  - G1 and G2 each last 1 cycle.
  - Period = 2·PH_CYC+2 cycles.
- Transitions:
  - IDLE→P1 on `start_i`.
  - P1→G1→P2→G2 in sequence.
  - G2→P1, or G2→IDLE if the run is ending.
- Output decode (Moore only; no input-to-output paths):
  - `phi1_o` = P1; `phi2_o` = P2; `cmp_latch_o` = G1; `enc_en_o` = G2; `busy_o` = state≠IDLE.
  - The gap states guarantee `phi1_o`/`phi2_o` non-overlap.
- Fill counter:
  - Cleared on start; counts G2 visits and saturates at FILL_LAT.
  - `valid_o` = G2 && fill count == FILL_LAT.
- `conv_cnt_o`:
  - Cleared on start; increments on each `valid_o`; saturates at 2^CNT_W−1.
  - Holds its value in IDLE.
- Stop:
  - `stop_i` while busy sets the `stop_pend` flag.
  - The current period completes through G2, then the FSM goes to IDLE.
  - `done_o` is high in the first IDLE cycle.
  - `stop_i` in IDLE is ignored.
- Command conflicts:
  - `start_i` while busy: ignored.
  - `start_i` and `stop_i` together in IDLE: start wins.
  - `start_i` in the IDLE cycle that carries `done_o`: a new run starts.
- Reset mid-run: the next edge forces IDLE and clears all flags and counters. No `done_o` is issued.

## Timing
- Reset values: every output 0, `conv_cnt_o` = 0, state IDLE.
- `start_i` sampled high at edge k: P1 is active from edge k, so `phi1_o` is high in cycle k.
- With PH_CYC=1:
  - Phase pattern per 4-cycle period: phi1, G1, phi2, G2.
  - `enc_en_o` in cycles k+3, k+7, …
  - First `valid_o` at k+15 (4th period).
- Stop: `done_o` asserts in the cycle after the G2 that ends the run.
- `busy_o` falls in that same cycle.

## Configuration
- Macro: `ADC_SEQ_BURST_EN`.
- Defined:
  - `burst_len_i` exists and is latched on start.
  - If nonzero, the run ends at the G2 where `conv_cnt_o` reaches `burst_len_i`, with `done_o` as for stop.
  - `stop_i` can still end a burst early.
  - `burst_len_i` = 0 means a continuous run.
- Undefined: the port is absent and runs are continuous until `stop_i`.

## Structure
- `adc_pipe_pkg` holds:
  - the FSM state enum (IDLE, P1, G1, P2, G2);
  - default `PH_CYC`/`FILL_LAT` localparams;
  - stage count 3.
- Sub-module `adc_pipe_phase_gen`: the FSM plus phase counter and output decode.
- The top module adds the start/stop/burst control, fill counter and conversion counter.

## Test plan
- Reset held 3 cycles with `start_i`=1: all outputs 0 and no run. After release, 1 cycle of `start_i` starts a run with `phi1_o` high that cycle.
- Continuous run, PH_CYC=1, FILL_LAT=3:
  - phases repeat as 1000/0010 for phi1/phi2;
  - `enc_en_o` every 4 cycles;
  - first `valid_o` at k+15;
  - `conv_cnt_o` = 5 after 8 periods.
- `stop_i` pulsed during P2 of period 6: G2 completes, `done_o` one cycle, `busy_o` 0, `conv_cnt_o` = 3 held. Later `stop_i` pulses have no effect.
- `ADC_SEQ_BURST_EN`, `burst_len_i`=5: exactly 5 `valid_o` pulses, then `done_o` and IDLE. With `burst_len_i`=0 the run is still active after 50 periods.
- PH_CYC=3: period 8, `phi1_o` high 3 cycles, one-cycle gaps, never overlapping `phi2_o`. `start_i` pulsed mid-run is ignored.
- `reset_i` asserted during P1 of period 2: IDLE on the next edge, `done_o` stays 0, `conv_cnt_o` = 0.
